serial_frame_rx: RTL



---
 rtl/serial_frame_rx_if.sv | 28 ++
 rtl/serial_frame_rx.sv | 116 +++++++++++
 2 files changed

// File: rtl/serial_frame_rx_if.sv
// Bus bundle for serial_frame_rx: serial frame input, valid/ready word output
// and status. master is the receiver side, slave is the driver/consumer side.
interface serial_frame_rx_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             serial_in;
  logic             start_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in;
  logic [LW-1:0]    level;
  logic             frame_err;
  logic             overflow;
  logic             clr_ovf;

  modport master (
    input  serial_in, start_in, ready_in, clr_ovf,
    output data_out, valid_out, level, frame_err, overflow
  );

  modport slave (
    output serial_in, start_in, ready_in, clr_ovf,
    input  data_out, valid_out, level, frame_err, overflow
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Framed serial deserializer: rebuilds MSB-first WIDTH-bit words, flags
// mid-frame restarts and queues completed words in a DEPTH-entry FIFO.
module serial_frame_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  serial_frame_rx_if.master bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] word;
  logic             push;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             pop, full, wr_en;

  // Bits enter at the LSB, so after WIDTH samples the first bit sits at the MSB.
  assign word = {sh_q[WIDTH-2:0], bus.serial_in};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          sh_d    = {{(WIDTH-1){1'b0}}, bus.serial_in};
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.start_in) begin
          // Restart wins even on the final bit: the partial word is discarded.
          sh_d        = {{(WIDTH-1){1'b0}}, bus.serial_in};
          cnt_d       = CW'(1);
          frame_err_d = 1'b1;
        end else if (cnt_q == CW'(WIDTH-1)) begin
          sh_d    = word;
          cnt_d   = '0;
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          sh_d  = word;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop   = (lvl_q != '0) && bus.ready_in;
    full  = (lvl_q == LW'(DEPTH));
    wr_en = push && (!full || pop);
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (wr_en) begin
      mem_d[wp_q] = word;
      wp_d        = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    lvl_d = lvl_q + LW'(wr_en) - LW'(pop);
    overflow_d = overflow_q;
    if (push && full && !pop) overflow_d = 1'b1;
    else if (bus.clr_ovf)     overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wp_q        <= '0;
      rp_q        <= '0;
      lvl_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      lvl_q       <= lvl_d;
      mem_q       <= mem_d;
    end
  end

  // Head is forced to zero while empty so stale entries never show.
  assign bus.data_out  = (lvl_q != '0) ? mem_q[rp_q] : '0;
  assign bus.valid_out = (lvl_q != '0);
  assign bus.level     = lvl_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;
endmodule
